// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state type and encodings.
package serial_add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t RUN  = 2'b01;
    localparam state_t DONE = 2'b10;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side handshake and operand/result bus of the serial adder controller.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single 1-bit full-adder cell; the only arithmetic in the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full-adder cell over WIDTH cycles, LSB
// first, and presents a registered {cout,sum} with a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    import serial_add_pkg::*;

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] res_next;

    full_adder_cell u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    // res_sr keeps only the upper WIDTH-1 bits; the LSB would fall off before use.
    assign res_next = {cell_s, res_sr};

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.op_a;
                        b_sr  <= bus.op_b;
                        carry <= bus.cin;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_sr <= res_next[WIDTH-1:1];
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= cell_co;
                    if (count == LAST) begin
                        sum_q  <= res_next;
                        cout_q <= cell_co;
                        state  <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=8 vector table plus corner sequences,
// and an exhaustive sweep of a WIDTH=2 instance.
module tb_serial_add_ctrl;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ticks until done is seen (bounded), tracking output hold and busy before it.
    task automatic wait_done8(input logic [7:0] hs, input logic hc,
                              output int cyc, output bit held, output bit busy_ok);
        cyc     = 0;
        held    = 1'b1;
        busy_ok = 1'b1;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (bus8.done === 1'b1) break;
            if (bus8.sum !== hs || bus8.cout !== hc) held = 1'b0;
            if (bus8.busy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    task automatic run8(input vec_t v, input string nm);
        logic [7:0] hs;
        logic       hc;
        int         cyc;
        bit         held;
        bit         busy_ok;
        hs = bus8.sum;
        hc = bus8.cout;
        bus8.op_a  = v.a;
        bus8.op_b  = v.b;
        bus8.cin   = v.c;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.op_a  = ~v.a;
        bus8.op_b  = ~v.b;
        bus8.cin   = ~v.c;
        check({nm, " busy_after_accept"}, {31'd0, bus8.busy}, 32'd1);
        wait_done8(hs, hc, cyc, held, busy_ok);
        check({nm, " latency"}, cyc, 32'd8);
        check({nm, " hold_during_run"}, {31'd0, held}, 32'd1);
        check({nm, " busy_during_run"}, {31'd0, busy_ok}, 32'd1);
        check({nm, " busy_at_done"}, {31'd0, bus8.busy}, 32'd0);
        check({nm, " sum"}, {24'd0, bus8.sum}, {24'd0, v.exp_sum});
        check({nm, " cout"}, {31'd0, bus8.cout}, {31'd0, v.exp_cout});
        tick();
        check({nm, " done_one_cycle"}, {31'd0, bus8.done}, 32'd0);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c);
        int         cyc;
        int         extra;
        logic [2:0] exp;
        exp = {1'b0, a} + {1'b0, b} + {2'b00, c};
        bus2.op_a  = a;
        bus2.op_b  = b;
        bus2.cin   = c;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        bus2.op_a  = ~a;
        bus2.op_b  = ~b;
        cyc = 0;
        while (cyc < 10) begin
            tick();
            cyc++;
            if (bus2.done === 1'b1) break;
        end
        check($sformatf("w2 %0d+%0d+%0d latency", a, b, c), cyc, 32'd2);
        check($sformatf("w2 %0d+%0d+%0d result", a, b, c),
              {29'd0, bus2.cout, bus2.sum}, {29'd0, exp});
        extra = 0;
        repeat (4) begin
            tick();
            if (bus2.done === 1'b1) extra++;
        end
        check($sformatf("w2 %0d+%0d+%0d single_done", a, b, c), extra, 32'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int         cyc;
        int         cnt_done;
        int         cnt_busy;
        bit         held;
        bit         busy_ok;
        logic [7:0] hs;
        logic       hc;

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.op_a  = 8'($urandom);
        bus8.op_b  = 8'($urandom);
        bus8.cin   = 1'($urandom);
        bus2.start = 1'b0;
        bus2.op_a  = 2'($urandom);
        bus2.op_b  = 2'($urandom);
        bus2.cin   = 1'b0;

        // Reset state
        #3;
        check("reset busy", {31'd0, bus8.busy}, 32'd0);
        check("reset done", {31'd0, bus8.done}, 32'd0);
        check("reset sum",  {24'd0, bus8.sum},  32'd0);
        check("reset cout", {31'd0, bus8.cout}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        cnt_done = 0;
        cnt_busy = 0;
        repeat (20) begin
            tick();
            if (bus8.done === 1'b1) cnt_done++;
            if (bus8.busy === 1'b1) cnt_busy++;
        end
        check("idle no_done", cnt_done, 32'd0);
        check("idle no_busy", cnt_busy, 32'd0);

        // Table-driven WIDTH=8 vectors
        for (int i = 0; i < 9; i++) begin
            run8(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back with start held high; operands change mid-run
        hs = bus8.sum;
        hc = bus8.cout;
        bus8.op_a  = 8'h11;
        bus8.op_b  = 8'h22;
        bus8.cin   = 1'b0;
        bus8.start = 1'b1;
        tick();
        repeat (3) tick();
        bus8.op_a = 8'h40;
        bus8.op_b = 8'h01;
        wait_done8(hs, hc, cyc, held, busy_ok);
        check("b2b first latency", cyc, 32'd5);
        check("b2b first hold", {31'd0, held}, 32'd1);
        check("b2b first sum", {24'd0, bus8.sum}, 32'h33);
        wait_done8(8'h33, 1'b0, cyc, held, busy_ok);
        check("b2b period", cyc, 32'd10);
        check("b2b hold_prev_result", {31'd0, held}, 32'd1);
        check("b2b second sum", {24'd0, bus8.sum}, 32'h41);
        bus8.start = 1'b0;
        cnt_busy = 0;
        repeat (6) begin
            tick();
            if (bus8.busy === 1'b1) cnt_busy++;
        end
        check("b2b stop_after_release", cnt_busy, 32'd0);

        // Reset during the 4th RUN cycle
        bus8.op_a  = 8'h55;
        bus8.op_b  = 8'h0F;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (3) tick();
        check("abort running", {31'd0, bus8.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, bus8.busy}, 32'd0);
        check("abort sum",  {24'd0, bus8.sum},  32'd0);
        check("abort cout", {31'd0, bus8.cout}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        cnt_done = 0;
        repeat (12) begin
            tick();
            if (bus8.done === 1'b1) cnt_done++;
        end
        check("abort no_done", cnt_done, 32'd0);
        run8('{8'h10, 8'h20, 1'b0, 8'h30, 1'b0}, "after_abort");

        // Exhaustive WIDTH=2
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    run2(2'(a), 2'(b), 1'(c));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
